mem_access_unit: RTL and testbench

- Sits in the MEM stage between the EX/MEM pipeline register and the word-organised data memory.
- Checks that each load/store is aligned and in range, and raises address-error exceptions for illegal accesses, so the data memory only ever sees legal accesses.
- The data memory zero-fills the unwritten bytes of a word on partial stores, so this block performs read-modify-write (RMW) for sb/sh. It stalls the pipeline for one extra cycle while doing so.
- Registers the load result and the exception outputs for the MEM/WB stage.

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store front end for a word-organised data memory.
//   - Screens every request for alignment, legal size and address range, and
//     turns illegal ones into registered address-error exceptions. The memory
//     never sees an illegal access.
//   - The data memory zero-fills unwritten bytes on a write, so sub-word stores
//     are done as read-modify-write: one cycle reads the word into merge_buf,
//     and the next cycle writes the merged word back. This costs one stall cycle.
//   - Load data comes back from the memory already lane-selected and extended.
//     It is taken directly into the MEM/WB response register.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid             memory instruction present in MEM
//   req_is_store          1 = store, 0 = load
//   req_size[1:0]         00 word, 01 half, 11 byte, 10 illegal
//   req_signed            sign-extend sub-word loads
//   req_addr[31:0]        byte address
//   req_wdata[31:0]       right-aligned store data
//   req_flush             abort the current request
//   req_ready             request completes at this edge (low = stall)
//   resp_valid            registered completion pulse
//   resp_rdata[31:0]      registered load data (0 after stores)
//   exc_adel / exc_ades   registered load / store address error pulses
//   exc_badvaddr[31:0]    registered faulting address
//   mem_address[31:0]     data memory byte address
//   mem_wdata[31:0]       data memory write word
//   mem_read_option[1:0]  00 word, 01 half, 11 byte, 10 none
//   mem_write_option[1:0] 00 word, 10 none
//   mem_extra_op          sign-extend request to memory (= req_signed)
//   mem_rdata[31:0]       combinational read data from memory
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | accept requests; loads, word stores and errors finish in 1 cycle
// MERGE  | second cycle of a sub-word store: write merge_buf with new lane
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int PHYS_LW = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_is_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_flush,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic [31:0] exc_badvaddr,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_read_option,
   output logic [1:0]  mem_write_option,
   output logic        mem_extra_op,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b11;
   localparam logic [1:0] OPT_NONE = 2'b10;
   localparam int RANGE_LSB = PHYS_LW + 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] merge_buf;

   logic        active;
   logic        size_ok;
   logic        align_ok;
   logic        range_ok;
   logic        legal;
   logic        sub_word;
   logic [31:0] merged;

   // A flushed request is treated exactly like no request.
   assign active   = req_valid & ~req_flush;
   assign size_ok  = (req_size != 2'b10);
   assign range_ok = (req_addr[31:RANGE_LSB] == '0);
   assign sub_word = (req_size != SZ_WORD);
   assign legal    = size_ok & align_ok & range_ok;

   always_comb begin
      align_ok = 1'b0;
      case (req_size)
         SZ_WORD: align_ok = (req_addr[1:0] == 2'b00);
         SZ_HALF: align_ok = ~req_addr[0];
         SZ_BYTE: align_ok = 1'b1;
         default: align_ok = 1'b0;
      endcase
   end

   // Replace the addressed lane of the previously read word with store data.
   always_comb begin
      merged = merge_buf;
      case (req_size)
         SZ_BYTE: merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
         SZ_HALF: merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
         default: merged = merge_buf;
      endcase
   end

   assign mem_address  = req_addr;
   assign mem_extra_op = req_signed;

   always_comb begin
      mem_read_option  = OPT_NONE;
      mem_write_option = OPT_NONE;
      mem_wdata        = req_wdata;
      req_ready        = 1'b1;
      case (state)
         ST_IDLE: begin
            if (active && legal) begin
               if (!req_is_store) begin
                  mem_read_option = req_size;
               end else if (!sub_word) begin
                  mem_write_option = SZ_WORD;
               end else begin
                  mem_read_option = SZ_WORD;
                  req_ready       = 1'b0;
               end
            end
         end
         ST_MERGE: begin
            if (active) begin
               mem_write_option = SZ_WORD;
               mem_wdata        = merged;
            end
         end
         default: ;
      endcase
      // Keep the memory quiet for the whole reset assertion, not just from
      // the state change onward.
      if (!rst_n) begin
         mem_read_option  = OPT_NONE;
         mem_write_option = OPT_NONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         merge_buf    <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         exc_adel     <= 1'b0;
         exc_ades     <= 1'b0;
         exc_badvaddr <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         exc_adel   <= 1'b0;
         exc_ades   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (active) begin
                  if (!legal) begin
                     exc_adel     <= ~req_is_store;
                     exc_ades     <= req_is_store;
                     exc_badvaddr <= req_addr;
                  end else if (!req_is_store) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= mem_rdata;
                  end else if (!sub_word) begin
                     resp_valid <= 1'b1;
                  end else begin
                     merge_buf <= mem_rdata;
                     state     <= ST_MERGE;
                  end
               end
            end
            ST_MERGE: begin
               // The write happens at this edge unless the request was aborted.
               resp_valid <= active;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int PHYS_LW = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_is_store = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_flush = 1'b0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        exc_adel;
   logic        exc_ades;
   logic [31:0] exc_badvaddr;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_read_option;
   logic [1:0]  mem_write_option;
   logic        mem_extra_op;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.PHYS_LW(PHYS_LW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_is_store     (req_is_store),
      .req_size         (req_size),
      .req_signed       (req_signed),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_flush        (req_flush),
      .req_ready        (req_ready),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .exc_adel         (exc_adel),
      .exc_ades         (exc_ades),
      .exc_badvaddr     (exc_badvaddr),
      .mem_address      (mem_address),
      .mem_wdata        (mem_wdata),
      .mem_read_option  (mem_read_option),
      .mem_write_option (mem_write_option),
      .mem_extra_op     (mem_extra_op),
      .mem_rdata        (mem_rdata)
   );

   // Data memory model: word array, combinational formatted read, write at edge.
   logic [31:0]        mem [0:(1<<PHYS_LW)-1];
   logic [PHYS_LW-1:0] widx;
   logic [31:0]        rd_word;
   logic [15:0]        rd_half;
   logic [7:0]         rd_byte;

   assign widx = mem_address[PHYS_LW+1:2];

   always_comb begin
      rd_word   = mem[widx];
      rd_half   = mem_address[1] ? rd_word[31:16] : rd_word[15:0];
      rd_byte   = rd_word[{mem_address[1:0], 3'b000} +: 8];
      mem_rdata = '0;
      case (mem_read_option)
         2'b00:   mem_rdata = rd_word;
         2'b01:   mem_rdata = {{16{mem_extra_op & rd_half[15]}}, rd_half};
         2'b11:   mem_rdata = {{24{mem_extra_op & rd_byte[7]}}, rd_byte};
         default: mem_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_write_option == 2'b00) mem[widx] <= mem_wdata;
   end

   typedef struct {
      string       name;
      logic        st;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_valid;
      logic [31:0] e_rdata;
      logic        e_adel;
      logic        e_ades;
      int          e_stall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic st, logic [1:0] sz, logic sg,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic e_valid, logic [31:0] e_rdata,
                               logic e_adel, logic e_ades, int e_stall);
      vec_t v;
      v.name = name; v.st = st; v.sz = sz; v.sg = sg; v.addr = addr;
      v.wdata = wdata; v.e_valid = e_valid; v.e_rdata = e_rdata;
      v.e_adel = e_adel; v.e_ades = e_ades; v.e_stall = e_stall;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called right after a falling edge; returns right after the falling edge
   // that follows the completing rising edge.
   task automatic run_req(input vec_t v);
      int   stall;
      logic accessed;
      req_valid    = 1'b1;
      req_is_store = v.st;
      req_size     = v.sz;
      req_signed   = v.sg;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_flush    = 1'b0;
      #1;
      accessed = (mem_read_option != 2'b10) || (mem_write_option != 2'b10);
      check({v.name, " access"}, {31'd0, accessed}, {31'd0, ~(v.e_adel | v.e_ades)});
      stall = 0;
      while (!req_ready && stall < 8) begin
         @(negedge clk);
         #1;
         stall++;
      end
      if (stall >= 8) begin
         errors++;
         $display("FAIL %s timeout: req_ready stuck low", v.name);
      end
      check({v.name, " stall"}, stall, v.e_stall);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check({v.name, " resp_valid"}, {31'd0, resp_valid}, {31'd0, v.e_valid});
      check({v.name, " rdata"}, resp_rdata, v.e_rdata);
      check({v.name, " adel"}, {31'd0, exc_adel}, {31'd0, v.e_adel});
      check({v.name, " ades"}, {31'd0, exc_ades}, {31'd0, v.e_ades});
      if (v.e_adel || v.e_ades) check({v.name, " badvaddr"}, exc_badvaddr, v.addr);
   endtask

   initial begin
      //          name        st    sz     sg    addr      wdata          vld   rdata          adel  ades  stall
      vecs.push_back(mk("sw10",   1'b1, 2'b00, 1'b0, 32'h10,  32'h12345678, 1'b1, 32'h0,        1'b0, 1'b0, 0));
      vecs.push_back(mk("lw10",   1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        1'b1, 32'h12345678, 1'b0, 1'b0, 0));
      vecs.push_back(mk("sw20",   1'b1, 2'b00, 1'b0, 32'h20,  32'hAABBCCDD, 1'b1, 32'h0,        1'b0, 1'b0, 0));
      vecs.push_back(mk("sb22",   1'b1, 2'b11, 1'b0, 32'h22,  32'hFFFFFF11, 1'b1, 32'h0,        1'b0, 1'b0, 1));
      vecs.push_back(mk("lw20a",  1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        1'b1, 32'hAA11CCDD, 1'b0, 1'b0, 0));
      vecs.push_back(mk("lbu22",  1'b0, 2'b11, 1'b0, 32'h22,  32'h0,        1'b1, 32'h00000011, 1'b0, 1'b0, 0));
      vecs.push_back(mk("sw30",   1'b1, 2'b00, 1'b0, 32'h30,  32'h80017FFF, 1'b1, 32'h0,        1'b0, 1'b0, 0));
      vecs.push_back(mk("lh32",   1'b0, 2'b01, 1'b1, 32'h32,  32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0, 0));
      vecs.push_back(mk("lhu32",  1'b0, 2'b01, 1'b0, 32'h32,  32'h0,        1'b1, 32'h00008001, 1'b0, 1'b0, 0));
      vecs.push_back(mk("lh30",   1'b0, 2'b01, 1'b1, 32'h30,  32'h0,        1'b1, 32'h00007FFF, 1'b0, 1'b0, 0));
      vecs.push_back(mk("lw13",   1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 0));
      vecs.push_back(mk("sw14",   1'b1, 2'b00, 1'b0, 32'h14,  32'h55667788, 1'b1, 32'h0,        1'b0, 1'b0, 0));
      vecs.push_back(mk("sh15",   1'b1, 2'b01, 1'b0, 32'h15,  32'h0000BEEF, 1'b0, 32'h0,        1'b0, 1'b1, 0));
      vecs.push_back(mk("lw14",   1'b0, 2'b00, 1'b0, 32'h14,  32'h0,        1'b1, 32'h55667788, 1'b0, 1'b0, 0));
      vecs.push_back(mk("lw1000", 1'b0, 2'b00, 1'b0, 32'h1000,32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 0));
      vecs.push_back(mk("sw1000", 1'b1, 2'b00, 1'b0, 32'h1000,32'h1,        1'b0, 32'h0,        1'b0, 1'b1, 0));
      vecs.push_back(mk("sz10",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 0));
      vecs.push_back(mk("sh22",   1'b1, 2'b01, 1'b0, 32'h22,  32'h1234BEEF, 1'b1, 32'h0,        1'b0, 1'b0, 1));
      vecs.push_back(mk("lw20b",  1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        1'b1, 32'hBEEFCCDD, 1'b0, 1'b0, 0));
      vecs.push_back(mk("sb23",   1'b1, 2'b11, 1'b0, 32'h23,  32'h00000099, 1'b1, 32'h0,        1'b0, 1'b0, 1));
      vecs.push_back(mk("lb23",   1'b0, 2'b11, 1'b1, 32'h23,  32'h0,        1'b1, 32'hFFFFFF99, 1'b0, 1'b0, 0));
      vecs.push_back(mk("sb20",   1'b1, 2'b11, 1'b0, 32'h20,  32'h00000042, 1'b1, 32'h0,        1'b0, 1'b0, 1));
      vecs.push_back(mk("lw20c",  1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        1'b1, 32'h99EFCC42, 1'b0, 1'b0, 0));
      vecs.push_back(mk("swFFC",  1'b1, 2'b00, 1'b0, 32'hFFC, 32'h7F000000, 1'b1, 32'h0,        1'b0, 1'b0, 0));
      vecs.push_back(mk("lbFFF",  1'b0, 2'b11, 1'b1, 32'hFFF, 32'h0,        1'b1, 32'h0000007F, 1'b0, 1'b0, 0));
      vecs.push_back(mk("sh21",   1'b1, 2'b01, 1'b0, 32'h21,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 0));
      vecs.push_back(mk("sw40",   1'b1, 2'b00, 1'b0, 32'h40,  32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 1'b0, 0));

      // Reset state
      repeat (2) @(negedge clk);
      check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst rdata", resp_rdata, 32'd0);
      check("rst adel", {31'd0, exc_adel}, 32'd0);
      check("rst ades", {31'd0, exc_ades}, 32'd0);
      check("rst badvaddr", exc_badvaddr, 32'd0);
      check("rst ready", {31'd0, req_ready}, 32'd1);
      check("rst wopt", {30'd0, mem_write_option}, 32'd2);
      check("rst ropt", {30'd0, mem_read_option}, 32'd2);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_req(vecs[i]);

      // Responses are single-cycle pulses
      @(negedge clk);
      check("pulse end", {31'd0, resp_valid}, 32'd0);

      // Flush during MERGE: write suppressed, no response
      req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b11; req_signed = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h11; req_flush = 1'b0;
      #1;
      check("flush ready0", {31'd0, req_ready}, 32'd0);
      check("flush rmw read", {30'd0, mem_read_option}, 32'd0);
      @(negedge clk);
      req_flush = 1'b1;
      #1;
      check("flush wopt", {30'd0, mem_write_option}, 32'd2);
      check("flush ready1", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_flush = 1'b0;
      @(negedge clk);
      check("flush resp_valid", {31'd0, resp_valid}, 32'd0);
      check("flush ades", {31'd0, exc_ades}, 32'd0);
      run_req(mk("lw40a", 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 0));

      // Reset pulse during MERGE: no write, everything back to idle
      run_req(mk("lw13b", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0));
      req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b11; req_signed = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h22; req_flush = 1'b0;
      @(negedge clk);
      #1;
      check("rmw wopt", {30'd0, mem_write_option}, 32'd0);
      check("rmw wdata", mem_wdata, 32'hCAFEF022);
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      check("mrst wopt", {30'd0, mem_write_option}, 32'd2);
      check("mrst ready", {31'd0, req_ready}, 32'd1);
      check("mrst resp_valid", {31'd0, resp_valid}, 32'd0);
      check("mrst badvaddr", exc_badvaddr, 32'd0);
      check("mrst adel", {31'd0, exc_adel}, 32'd0);
      check("mrst rdata", resp_rdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_req(mk("lw40b", 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
